// File: rtl/chess_value_scheduler.sv
// chess_value_scheduler
// Walks every cell of a BOARD_N x BOARD_N Gobang board. For each empty cell it
// gathers the 9-cell line pattern in four directions, scores each line twice
// on a shared combinational scorer (attack with own stones, defence with the
// colours swapped), sums the eight scores and keeps the best cell.
//
// Handshakes:
//   start/busy/done : start is a one-cycle pulse honoured only in IDLE; busy is
//                     high from the next cycle until the scan ends; done pulses
//                     for one cycle in FIN while busy is already low.
//   rd_en/rd_data   : a read strobe with rd_addr in cycle t returns the cell
//                     code on rd_data in cycle t+1. There is no back-pressure.
//
// Timing per cell: an occupied cell costs CHK + CHKW = 2 cycles. An empty cell
// costs CHK + CHKW + 4 * (9 LOAD + WAIT + EATK + EDEF) + NDIR = 51 cycles. To
// hit those counts the direction step is taken on the exit of EDEF, and the
// step to the next cell position is taken on the exit of CHKW (occupied) or
// NDIR (after the compare), so neither costs a cycle of its own.
module chess_value_scheduler #(
  parameter int BOARD_N   = 15,
  parameter int ADDR_W    = 8,
  parameter int SCORE_W   = 16,
  parameter int DEF_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [1:0]           rd_data,
  output logic [8:0]           calc_my,
  output logic [8:0]           calc_op,
  output logic [8:0]           calc_gr,
  input  logic [SCORE_W-1:0]   calc_score,
  output logic [3:0]           best_row,
  output logic [3:0]           best_col,
  output logic [SCORE_W+2:0]   best_score,
  output logic                 best_valid,
  output logic [3:0]           dbg_state
);

  localparam int ACC_W = SCORE_W + 3;
  localparam logic [3:0] LAST = 4'(BOARD_N - 1);
  localparam logic signed [6:0] N_S = 7'(BOARD_N);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CHK  = 4'd1,
    S_CHKW = 4'd2,
    S_LOAD = 4'd3,
    S_WAIT = 4'd4,
    S_EATK = 4'd5,
    S_EDEF = 4'd6,
    S_NDIR = 4'd7,
    S_FIN  = 4'd8
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Pattern registers: own stones, opponent stones, off-board mask.
  logic [8:0] my_q, my_d;
  logic [8:0] op_q, op_d;
  logic [8:0] gr_q, gr_d;

  // Capture pipeline: the tap issued in LOAD lands in its bit one cycle later.
  logic       cap_vld_q, cap_vld_d;
  logic [3:0] cap_k_q, cap_k_d;
  logic       cap_off_q, cap_off_d;

  logic [3:0]       best_row_q, best_row_d;
  logic [3:0]       best_col_q, best_col_d;
  logic [ACC_W-1:0] best_score_q, best_score_d;
  logic             best_valid_q, best_valid_d;

  // Tap geometry for the current (row, col, dir, k).
  logic signed [6:0] row_s, col_s, tap_off, tap_r, tap_c;
  logic              tap_on;
  logic [ADDR_W-1:0] tap_addr;

  // Next cell position in row-major order.
  logic [3:0] npos_row, npos_col;
  logic       pos_last;
  logic       cell_occupied;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
    return ADDR_W'(r) * ADDR_W'(BOARD_N) + ADDR_W'(c);
  endfunction

  // Position of pattern bit k: offset (k-4) along the direction vector.
  always_comb begin
    row_s   = $signed({3'b000, row_q});
    col_s   = $signed({3'b000, col_q});
    tap_off = $signed({3'b000, k_q}) - 7'sd4;
    tap_r   = row_s;
    tap_c   = col_s;
    case (dir_q)
      2'd0: begin tap_r = row_s;           tap_c = col_s + tap_off; end
      2'd1: begin tap_r = row_s + tap_off; tap_c = col_s;           end
      2'd2: begin tap_r = row_s + tap_off; tap_c = col_s + tap_off; end
      default: begin tap_r = row_s + tap_off; tap_c = col_s - tap_off; end
    endcase
    tap_on   = (tap_r >= 7'sd0) && (tap_r < N_S) && (tap_c >= 7'sd0) && (tap_c < N_S);
    tap_addr = cell_addr(tap_r[3:0], tap_c[3:0]);
  end

  // Row-major advance and end-of-board detection.
  always_comb begin
    pos_last      = (row_q == LAST) && (col_q == LAST);
    cell_occupied = (rd_data == 2'b01) || (rd_data == 2'b10);
    if (col_q == LAST) begin
      npos_col = 4'd0;
      npos_row = row_q + 4'd1;
    end else begin
      npos_col = col_q + 4'd1;
      npos_row = row_q;
    end
  end

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    dir_d        = dir_q;
    k_d          = k_q;
    acc_d        = acc_q;
    my_d         = my_q;
    op_d         = op_q;
    gr_d         = gr_q;
    cap_vld_d    = 1'b0;
    cap_k_d      = cap_k_q;
    cap_off_d    = 1'b0;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    best_score_d = best_score_q;
    best_valid_d = best_valid_q;
    rd_en        = 1'b0;
    rd_addr      = '0;
    calc_my      = '0;
    calc_op      = '0;
    calc_gr      = '0;

    // Land the tap issued last cycle; off-board taps read nothing.
    if (cap_vld_q) begin
      if (cap_off_q) begin
        my_d[cap_k_q] = 1'b0;
        op_d[cap_k_q] = 1'b0;
        gr_d[cap_k_q] = 1'b1;
      end else begin
        my_d[cap_k_q] = (rd_data == 2'b01);
        op_d[cap_k_q] = (rd_data == 2'b10);
        gr_d[cap_k_q] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          best_row_d   = '0;
          best_col_d   = '0;
          best_score_d = '0;
          best_valid_d = 1'b0;
          row_d        = '0;
          col_d        = '0;
          state_d      = S_CHK;
        end
      end
      S_CHK: begin
        rd_en   = 1'b1;
        rd_addr = cell_addr(row_q, col_q);
        state_d = S_CHKW;
      end
      S_CHKW: begin
        if (cell_occupied) begin
          if (pos_last) begin
            state_d = S_FIN;
          end else begin
            row_d   = npos_row;
            col_d   = npos_col;
            state_d = S_CHK;
          end
        end else begin
          acc_d   = '0;
          dir_d   = 2'd0;
          k_d     = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rd_en     = tap_on;
        rd_addr   = tap_on ? tap_addr : '0;
        cap_vld_d = 1'b1;
        cap_k_d   = k_q;
        cap_off_d = !tap_on;
        if (k_q == 4'd8) begin
          state_d = S_WAIT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_WAIT: begin
        state_d = S_EATK;
      end
      S_EATK: begin
        calc_my = my_q;
        calc_op = op_q;
        calc_gr = gr_q;
        acc_d   = acc_q + ACC_W'(calc_score);
        state_d = S_EDEF;
      end
      S_EDEF: begin
        calc_my = op_q;
        calc_op = my_q;
        calc_gr = gr_q;
        acc_d   = acc_q + ACC_W'(calc_score >> DEF_SHIFT);
        if (dir_q != 2'd3) begin
          dir_d   = dir_q + 2'd1;
          k_d     = 4'd0;
          state_d = S_LOAD;
        end else begin
          state_d = S_NDIR;
        end
      end
      S_NDIR: begin
        // Strictly greater wins, so the earliest cell keeps a tie.
        if ((acc_q > best_score_q) || !best_valid_q) begin
          best_row_d   = row_q;
          best_col_d   = col_q;
          best_score_d = acc_q;
        end
        best_valid_d = 1'b1;
        if (pos_last) begin
          state_d = S_FIN;
        end else begin
          row_d   = npos_row;
          col_d   = npos_col;
          state_d = S_CHK;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      dir_q        <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      my_q         <= '0;
      op_q         <= '0;
      gr_q         <= '0;
      cap_vld_q    <= 1'b0;
      cap_k_q      <= '0;
      cap_off_q    <= 1'b0;
      best_row_q   <= '0;
      best_col_q   <= '0;
      best_score_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dir_q        <= dir_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      my_q         <= my_d;
      op_q         <= op_d;
      gr_q         <= gr_d;
      cap_vld_q    <= cap_vld_d;
      cap_k_q      <= cap_k_d;
      cap_off_q    <= cap_off_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
      best_score_q <= best_score_d;
      best_valid_q <= best_valid_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    done       = (state_q == S_FIN);
    best_row   = best_row_q;
    best_col   = best_col_q;
    best_score = best_score_q;
    best_valid = best_valid_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_chess_value_scheduler.sv
// Testbench for chess_value_scheduler. Two instances share one board image:
// u_dut_a uses DEF_SHIFT = 0, u_dut_b uses DEF_SHIFT = 1. A stub scorer sits
// on each instance and a whole-board reference model predicts the result.
module tb_chess_value_scheduler;

  localparam int N      = 15;
  localparam int CELLS  = N * N;
  localparam int ADDR_W = 8;
  localparam int SW     = 16;
  localparam int BUDGET = 12000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              a_busy, a_done, a_rd_en, a_valid;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [1:0]        a_rd_data = 2'b00;
  logic [8:0]        a_my, a_op, a_gr;
  logic [SW-1:0]     a_score;
  logic [3:0]        a_row, a_col, a_state;
  logic [SW+2:0]     a_best;

  logic              b_busy, b_done, b_rd_en, b_valid;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [1:0]        b_rd_data = 2'b00;
  logic [8:0]        b_my, b_op, b_gr;
  logic [SW-1:0]     b_score;
  logic [3:0]        b_row, b_col, b_state;
  logic [SW+2:0]     b_best;

  // ---------------- board memory and stub scorer ----------------
  logic [1:0] board [0:CELLS-1];
  int         stub_mode;
  logic [15:0] stub_const;

  function automatic logic [15:0] stub_score(input int mode, input logic [15:0] cval,
                                             input logic [8:0] my, input logic [8:0] op,
                                             input logic [8:0] gr);
    case (mode)
      0: return cval;
      // Three own stones directly left of an empty centre.
      1: return (my == 9'b000001110) ? 16'd100 : 16'd0;
      default: return 16'((my * 16'd37) ^ (op * 16'd11) ^ (gr * 16'd5));
    endcase
  endfunction

  assign a_score = stub_score(stub_mode, stub_const, a_my, a_op, a_gr);
  assign b_score = stub_score(stub_mode, stub_const, b_my, b_op, b_gr);

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= (int'(a_rd_addr) < CELLS) ? board[a_rd_addr] : 2'b00;
    if (b_rd_en) b_rd_data <= (int'(b_rd_addr) < CELLS) ? board[b_rd_addr] : 2'b00;
  end

  chess_value_scheduler #(.DEF_SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .calc_my(a_my), .calc_op(a_op), .calc_gr(a_gr), .calc_score(a_score),
    .best_row(a_row), .best_col(a_col), .best_score(a_best), .best_valid(a_valid),
    .dbg_state(a_state)
  );

  chess_value_scheduler #(.DEF_SHIFT(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .calc_my(b_my), .calc_op(b_op), .calc_gr(b_gr), .calc_score(b_score),
    .best_row(b_row), .best_col(b_col), .best_score(b_best), .best_valid(b_valid),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // Packed expectation: {valid, row[3:0], col[3:0], score[18:0]}
  logic [27:0] exp_q[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole-board reference: score every empty cell from its four line
  // patterns and keep the first strictly-best cell in row-major order.
  task automatic ref_scan(input int shift, output logic [27:0] res, output int lat);
    logic [8:0] my, op, gr;
    longint     sum, bs;
    int         br, bc, rr, cc, dr, dc;
    bit         bv;
    logic [1:0] code;
    bv = 0; br = 0; bc = 0; bs = 0; lat = 1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        code = board[r*N + c];
        if (code == 2'b01 || code == 2'b10) begin
          lat += 2;
        end else begin
          lat += 51;
          sum = 0;
          for (int d = 0; d < 4; d++) begin
            case (d)
              0: begin dr = 0; dc = 1;  end
              1: begin dr = 1; dc = 0;  end
              2: begin dr = 1; dc = 1;  end
              default: begin dr = 1; dc = -1; end
            endcase
            my = '0; op = '0; gr = '0;
            for (int k = 0; k < 9; k++) begin
              rr = r + (k - 4) * dr;
              cc = c + (k - 4) * dc;
              if (rr < 0 || rr >= N || cc < 0 || cc >= N) gr[k] = 1'b1;
              else if (board[rr*N + cc] == 2'b01) my[k] = 1'b1;
              else if (board[rr*N + cc] == 2'b10) op[k] = 1'b1;
            end
            sum += longint'(stub_score(stub_mode, stub_const, my, op, gr));
            sum += longint'(stub_score(stub_mode, stub_const, op, my, gr) >> shift);
          end
          if (!bv || sum > bs) begin
            bs = sum; br = r; bc = c;
          end
          bv = 1;
        end
      end
    end
    res = {bv, 4'(br), 4'(bc), 19'(bs)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_board(input int kind);
    int v;
    for (int i = 0; i < CELLS; i++) begin
      case (kind)
        0: board[i] = 2'b00;
        1: board[i] = 2'b01;
        default: begin
          v = $urandom_range(0, 9);
          if (v < 3)       board[i] = 2'b00;
          else if (v == 3) board[i] = 2'b11;
          else if (v < 7)  board[i] = 2'b01;
          else             board[i] = 2'b10;
        end
      endcase
    end
  endtask

  task automatic compare_result(input string tag, input logic [27:0] e,
                                input logic v, input logic [3:0] r,
                                input logic [3:0] c, input logic [SW+2:0] s);
    check_eq({tag, "_valid"}, v, e[27]);
    check_eq({tag, "_row"},   r, e[26:23]);
    check_eq({tag, "_col"},   c, e[22:19]);
    check_eq({tag, "_score"}, s, e[18:0]);
  endtask

  // Start a scan, optionally pulse start again mid-scan, optionally check the
  // corner cell's first direction, then compare both DUTs against the model.
  task automatic run_scan(input string tag, input int mid_start_at, input bit corner_chk,
                          output int cycles, output int reads);
    logic [27:0] e;
    int          lat;
    logic [8:0]  exp_my, exp_op;
    ref_scan(0, e, lat);
    exp_q.push_back(e);
    ref_scan(1, e, lat);
    exp_q.push_back(e);
    exp_my = '0;
    exp_op = '0;
    for (int k = 5; k < 9; k++) begin
      if (board[k-4] == 2'b01) exp_my[k] = 1'b1;
      if (board[k-4] == 2'b10) exp_op[k] = 1'b1;
    end
    @(negedge clk);
    start  = 1'b1;
    cycles = 0;
    reads  = 0;
    while (cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      start = (mid_start_at != 0) && (cycles == mid_start_at);
      if (a_rd_en) reads++;
      if (cycles == 1) check_eq({tag, "_busy_after_start"}, a_busy, 1);
      if (corner_chk) begin
        // LOAD of (0,0) direction 0 spans cycles 3..11; taps 0..3 are off-board.
        if (cycles >= 3 && cycles <= 11) begin
          check_eq({tag, "_corner_rd_en"}, a_rd_en, (cycles >= 7) ? 1 : 0);
          if (cycles >= 7) check_eq({tag, "_corner_rd_addr"}, a_rd_addr, cycles - 7);
        end
        if (cycles == 13) begin
          check_eq({tag, "_corner_atk_gr"}, a_gr, 9'b000001111);
          check_eq({tag, "_corner_atk_my"}, a_my, exp_my);
          check_eq({tag, "_corner_atk_op"}, a_op, exp_op);
        end
        if (cycles == 14) begin
          check_eq({tag, "_corner_def_gr"}, a_gr, 9'b000001111);
          check_eq({tag, "_corner_def_my"}, a_my, exp_op);
          check_eq({tag, "_corner_def_op"}, a_op, exp_my);
        end
      end
      if (a_done) break;
    end
    start = 1'b0;
    check_eq({tag, "_done_a"}, a_done, 1);
    check_eq({tag, "_done_b"}, b_done, 1);
    check_eq({tag, "_latency"}, cycles, lat);
    check_eq({tag, "_busy_at_done"}, a_busy, 0);
    e = exp_q.pop_front();
    compare_result({tag, "_a"}, e, a_valid, a_row, a_col, a_best);
    e = exp_q.pop_front();
    compare_result({tag, "_b"}, e, b_valid, b_row, b_col, b_best);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, a_done, 0);
  endtask

  // ---------------- test sequence ----------------
  int cyc, rds, first_empty, done_seen;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stub_mode  = 0;
    stub_const = 16'd5;
    fill_board(0);
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy",  a_busy, 0);
    check_eq("rst_done",  a_done, 0);
    check_eq("rst_rd_en", a_rd_en, 0);
    check_eq("rst_valid", a_valid, 0);
    check_eq("rst_score", a_best, 0);
    check_eq("rst_rowcol", {a_row, a_col}, 0);
    check_eq("rst_calc", {a_my, a_op, a_gr}, 0);
    check_eq("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Empty board, constant 5: every cell 40 (DEF_SHIFT=1 gives 28).
    run_scan("empty5", 0, 1, cyc, rds);
    check_eq("empty5_cycles", cyc, 225*51 + 1);
    check_eq("empty5_best_a", {a_row, a_col}, 0);
    check_eq("empty5_score_a", a_best, 40);
    check_eq("empty5_score_b", b_best, 28);

    // Full board: nothing to score, centre reads only.
    fill_board(1);
    run_scan("full", 0, 0, cyc, rds);
    check_eq("full_cycles", cyc, 225*2 + 1);
    check_eq("full_valid", a_valid, 0);
    check_eq("full_score", a_best, 0);
    check_eq("full_reads", rds, 225);

    // Pattern scorer: three own stones at (7,4),(7,5),(7,6) light up (7,7).
    fill_board(0);
    board[7*N + 4] = 2'b01;
    board[7*N + 5] = 2'b01;
    board[7*N + 6] = 2'b01;
    stub_mode = 1;
    run_scan("pattern", 0, 0, cyc, rds);
    check_eq("pattern_row", a_row, 7);
    check_eq("pattern_col", a_col, 7);
    check_eq("pattern_score_ge100", (a_best >= 100) ? 1 : 0, 1);

    // Random board with corner inspection.
    stub_mode = 2;
    fill_board(2);
    board[0] = 2'b00;
    run_scan("rand_corner", 0, 1, cyc, rds);

    // Random board with a stray start pulse mid-scan.
    fill_board(2);
    run_scan("rand_midstart", 300, 0, cyc, rds);

    // Constant 8 on a random board: first empty cell wins with 64 / 48.
    stub_mode  = 0;
    stub_const = 16'd8;
    fill_board(2);
    board[5] = 2'b00;
    first_empty = -1;
    for (int i = 0; i < CELLS; i++)
      if (first_empty < 0 && (board[i] == 2'b00 || board[i] == 2'b11)) first_empty = i;
    run_scan("const8", 0, 0, cyc, rds);
    check_eq("const8_score_a", a_best, 64);
    check_eq("const8_score_b", b_best, 48);
    check_eq("const8_cell", int'(a_row) * N + int'(a_col), first_empty);

    // Reset asserted mid-scan aborts it; a fresh start then completes.
    stub_mode = 2;
    fill_board(2);
    @(negedge clk);
    start     = 1'b1;
    done_seen = 0;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      start = (c == 200);
      if (a_done) done_seen++;
      if (c == 300) check_eq("abort_busy_mid", a_busy, 1);
    end
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check_eq("abort_no_done", done_seen, 0);
    check_eq("abort_busy", a_busy, 0);
    check_eq("abort_done", a_done, 0);
    check_eq("abort_valid", a_valid, 0);
    check_eq("abort_score", a_best, 0);
    check_eq("abort_rowcol", {a_row, a_col}, 0);
    check_eq("abort_b_busy", b_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan("after_abort", 0, 0, cyc, rds);

    // More random boards.
    for (int t = 0; t < 2; t++) begin
      fill_board(2);
      run_scan("rand_extra", 0, 0, cyc, rds);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
